// File: rtl/stopwatch_ctrl_fsm_pkg.sv
// Shared stopwatch definitions: FSM state encodings, debounce defaults and
// the event-driven next-state rule used by the run/pause sequencer.
package stopwatch_ctrl_fsm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSED = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  localparam int DB_CYCLES_DEFAULT = 1_000_000;
  localparam int DB_W_DEFAULT      = 20;

  // Transition taken when no clear event is present; time_out outranks pause,
  // pause outranks start, and losing events are simply dropped.
  function automatic logic [1:0] fsm_next(input logic [1:0] cur,
                                          input logic       start_ev,
                                          input logic       pause_ev,
                                          input logic       time_out);
    case (cur)
      ST_IDLE:   return start_ev ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (time_out)      return ST_DONE;
        else if (pause_ev) return ST_PAUSED;
        else               return ST_RUN;
      end
      ST_PAUSED: return (start_ev || pause_ev) ? ST_RUN : ST_PAUSED;
      ST_DONE:   return ST_DONE;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_fsm_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, hold-time debounce, rising-edge press pulse.
// Latency: stable raw rise after edge 0 -> press high after edge DB_CYCLES+3.
// No backpressure: press is a one-clk strobe, consumer must sample it that cycle.
module btn_debounce
  import stopwatch_ctrl_fsm_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = DB_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync_q1;
  logic            sync_q2;
  logic            db;
  logic            db_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      db      <= 1'b0;
      db_d    <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      db_d    <= db;
      press   <= db & ~db_d;
      // Any return to the accepted level restarts the hold count.
      if (sync_q2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync_q2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch run/pause/clear sequencer: debounced button events drive the IDLE/RUN/PAUSED/DONE FSM.
// Latency: state updates the clk after an event; clear strobe the clk after acceptance; count_en combinational.
// No backpressure: events and ticks are strobes, anything not acted on in its cycle is dropped.
module stopwatch_ctrl_fsm
  import stopwatch_ctrl_fsm_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = DB_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       tick_100hz,
  input  logic       time_out,
  output logic       count_en,
  output logic       clear,
  output logic       running,
  output logic [1:0] state
);

  logic       start_ev;
  logic       pause_ev;
  logic       clear_ev;
  logic [1:0] state_nxt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .press   (start_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_pause (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_pause),
    .press   (pause_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .press   (clear_ev)
  );

  always_comb begin
    state_nxt = fsm_next(state, start_ev, pause_ev, time_out);
    if (clear_ev) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      clear <= 1'b0;
    end else begin
      state <= state_nxt;
      clear <= clear_ev;
    end
  end

  // Qualified from registered state so a tick coinciding with RUN->PAUSED still counts.
  assign count_en = tick_100hz & (state == ST_RUN) & ~time_out;
  assign running  = (state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Scoreboard bench for stopwatch_ctrl_fsm with DB_CYCLES=4: stimulus queues expected
// events (count_en pulse, clear pulse, state change) with their cycle; a monitor pops and compares.
module tb_stopwatch_ctrl_fsm;
  import stopwatch_ctrl_fsm_pkg::*;

  localparam int K_COUNT = 0;
  localparam int K_CLEAR = 1;
  localparam int K_STATE = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clear = 1'b0;
  logic       tick_100hz = 1'b0;
  logic       time_out = 1'b0;
  logic       count_en;
  logic       clear;
  logic       running;
  logic [1:0] state;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;

  stopwatch_ctrl_fsm #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_clear  (btn_clear),
    .tick_100hz (tick_100hz),
    .time_out   (time_out),
    .count_en   (count_en),
    .clear      (clear),
    .running    (running),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int k, input int v, input int c);
    exp_q.push_back('{kind: k, val: v, cyc: c});
  endtask

  task automatic take(input int k, input int v);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, required no event", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_value", v, e.val);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: per cycle, report count, then clear, then state change.
  always @(negedge clk) begin
    if (mon_en) begin
      if (count_en) take(K_COUNT, 1);
      if (clear) take(K_CLEAR, 1);
      if (state != prev_state) begin
        take(K_STATE, int'(state));
        check("running", int'(running), int'(state == ST_RUN));
      end
    end
    prev_state = state;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the selected buttons long enough to be accepted, then release and settle.
  task automatic press(input bit s, input bit p, input bit c);
    btn_start = s;
    btn_pause = p;
    btn_clear = c;
    step(12);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_clear = 1'b0;
    step(12);
  endtask

  task automatic tick(input bit counted);
    if (counted) push(K_COUNT, 1, cyc);
    tick_100hz = 1'b1;
    step(1);
    tick_100hz = 1'b0;
    step(2);
  endtask

  task automatic press_expect(input bit s, input bit p, input bit c,
                              input bit exp_clr, input int exp_st);
    if (exp_clr) push(K_CLEAR, 1, cyc + 8);
    if (exp_st >= 0) push(K_STATE, exp_st, cyc + 8);
    press(s, p, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    int t;

    // Reset state
    step(2);
    tick_100hz = 1'b1;
    @(negedge clk);
    check("reset_state", int'(state), int'(ST_IDLE));
    check("reset_clear", int'(clear), 0);
    check("reset_running", int'(running), 0);
    check("reset_count_en", int'(count_en), 0);
    tick_100hz = 1'b0;
    step(1);
    rst = 1'b0;
    mon_en = 1'b1;
    step(2);

    // Debounce: bouncing start, then a stable rise gives one start event at +7
    for (int i = 0; i < 10; i++) begin
      btn_start = (i % 2 == 0);
      step(2);
    end
    push(K_STATE, 1, cyc + 8);
    btn_start = 1'b1;
    step(12);
    btn_start = 1'b0;
    step(12);

    // Run/pause: 5 counted ticks (last coincides with pause event), 3 ignored, 2 counted
    for (int i = 0; i < 4; i++) tick(1'b1);
    t = cyc;
    push(K_COUNT, 1, t + 7);
    push(K_STATE, 2, t + 8);
    fork
      press(1'b0, 1'b1, 1'b0);
      begin
        step(7);
        tick_100hz = 1'b1;
        step(1);
        tick_100hz = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) tick(1'b0);
    press_expect(1'b1, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 2; i++) tick(1'b1);
    press_expect(1'b0, 1'b0, 1'b1, 1'b1, 0);

    // Timeout: RUN -> DONE next clk, ticks gated, start/pause ignored, clear exits
    press_expect(1'b1, 1'b0, 1'b0, 1'b0, 1);
    time_out = 1'b1;
    push(K_STATE, 3, cyc + 1);
    tick(1'b0);
    tick(1'b0);
    press_expect(1'b1, 1'b0, 1'b0, 1'b0, -1);
    press_expect(1'b0, 1'b1, 1'b0, 1'b0, -1);
    press_expect(1'b0, 1'b0, 1'b1, 1'b1, 0);
    tick(1'b0);
    step(3);
    time_out = 1'b0;
    step(2);

    // Priority: clear beats pause in RUN
    press_expect(1'b1, 1'b0, 1'b0, 1'b0, 1);
    press_expect(1'b0, 1'b1, 1'b1, 1'b1, 0);

    // Priority: time_out beats pause in RUN
    press_expect(1'b1, 1'b0, 1'b0, 1'b0, 1);
    t = cyc;
    push(K_STATE, 3, t + 8);
    fork
      press(1'b0, 1'b1, 1'b0);
      begin
        step(7);
        time_out = 1'b1;
      end
    join
    time_out = 1'b0;
    step(2);
    press_expect(1'b0, 1'b0, 1'b1, 1'b1, 0);

    // Reset mid-run with start debounce in progress, start held through reset release
    press_expect(1'b1, 1'b0, 1'b0, 1'b0, 1);
    t = cyc;
    btn_start = 1'b1;
    push(K_STATE, 0, t + 5);
    push(K_STATE, 1, t + 13);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    tick_100hz = 1'b1;
    @(negedge clk);
    check("midrst_clear", int'(clear), 0);
    check("midrst_count_en", int'(count_en), 0);
    tick_100hz = 1'b0;
    step(12);
    btn_start = 1'b0;
    step(12);

    // Glitch rejection: 3-clk clear pulse while RUN does nothing
    btn_clear = 1'b1;
    step(3);
    btn_clear = 1'b0;
    step(15);
    tick(1'b1);
    press_expect(1'b0, 1'b0, 1'b1, 1'b1, 0);

    step(5);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
